// File: rtl/load_store_unit.sv
// Byte/half/word load-store engine between the pipeline and a word-addressed data memory.
// Latency: err 1, load 2, SW 2, SB/SH 3 cycles; req is sampled only in IDLE.
module load_store_unit #(
    parameter int DATA_LENGTH      = 32,
    parameter int DMEM_ADDR_LENGTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req,
    input  logic                        we,
    input  logic [2:0]                  funct3,
    input  logic [DMEM_ADDR_LENGTH-1:0] addr,
    input  logic [DATA_LENGTH-1:0]      wdata,
    output logic [DATA_LENGTH-1:0]      rdata,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [DMEM_ADDR_LENGTH-1:0] mem_addr,
    output logic [DATA_LENGTH-1:0]      mem_dataW,
    output logic                        mem_MemRW,
    input  logic [DATA_LENGTH-1:0]      mem_dataR
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t                      state_q, state_d;
    logic                        we_q, we_d;
    logic [2:0]                  funct3_q, funct3_d;
    logic [1:0]                  off_q, off_d;
    logic [15:0]                 wlo_q, wlo_d;
    logic [DATA_LENGTH-1:0]      rdata_q, rdata_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        err_q, err_d;
    logic [DMEM_ADDR_LENGTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_LENGTH-1:0]      mem_dataW_q, mem_dataW_d;
    logic                        mem_MemRW_q, mem_MemRW_d;

    logic                        illegal;
    logic                        misaligned;

    function automatic logic [DATA_LENGTH-1:0] merge_store(
        input logic [DATA_LENGTH-1:0] word,
        input logic                   is_half,
        input logic [1:0]             off,
        input logic [15:0]            wlo
    );
        logic [DATA_LENGTH-1:0] m;
        m = word;
        if (is_half) m[{off[1], 4'b0000} +: 16] = wlo;
        else         m[{off, 3'b000} +: 8]      = wlo[7:0];
        return m;
    endfunction

    function automatic logic [DATA_LENGTH-1:0] extract_load(
        input logic [DATA_LENGTH-1:0] word,
        input logic [2:0]             f3,
        input logic [1:0]             off
    );
        logic [7:0]             b;
        logic [15:0]            h;
        logic [DATA_LENGTH-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3[1:0])
            2'b00:   r = f3[2] ? {{(DATA_LENGTH-8){1'b0}}, b}  : {{(DATA_LENGTH-8){b[7]}}, b};
            2'b01:   r = f3[2] ? {{(DATA_LENGTH-16){1'b0}}, h} : {{(DATA_LENGTH-16){h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Sub-word stores may not use the unsigned codes; W needs both low bits clear.
    assign illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (we && funct3[2]);
    assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3 == 3'b010) && (addr[1:0] != 2'b00));

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        wlo_d       = wlo_q;
        rdata_d     = '0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_addr_d  = '0;
        mem_dataW_d = '0;
        mem_MemRW_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d     = we;
                    funct3_d = funct3;
                    off_d    = addr[1:0];
                    wlo_d    = wdata[15:0];
                    if (illegal || misaligned) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (we && (funct3 == 3'b010)) begin
                        state_d     = WR;
                        mem_addr_d  = {addr[DMEM_ADDR_LENGTH-1:2], 2'b00};
                        mem_dataW_d = wdata;
                        mem_MemRW_d = 1'b1;
                    end else begin
                        state_d    = RD;
                        mem_addr_d = {addr[DMEM_ADDR_LENGTH-1:2], 2'b00};
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    state_d     = WR;
                    mem_addr_d  = mem_addr_q;
                    mem_dataW_d = merge_store(mem_dataR, funct3_q[0], off_q, wlo_q);
                    mem_MemRW_d = 1'b1;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    rdata_d = extract_load(mem_dataR, funct3_q, off_q);
                end
            end
            WR: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            wlo_q       <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_dataW_q <= '0;
            mem_MemRW_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            wlo_q       <= wlo_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_dataW_q <= mem_dataW_d;
            mem_MemRW_q <= mem_MemRW_d;
        end
    end

    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_dataW = mem_dataW_q;
    assign mem_MemRW = mem_MemRW_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: negedge-updated word memory, arithmetic reference model,
// and one negedge compare process checking every cycle.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        busy, done, err;
    logic [31:0] mem_addr, mem_dataW;
    logic        mem_MemRW;
    logic [31:0] mem_dataR = '0;

    load_store_unit #(.DATA_LENGTH(32), .DMEM_ADDR_LENGTH(32)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_dataW(mem_dataW), .mem_MemRW(mem_MemRW),
        .mem_dataR(mem_dataR)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          req_cyc = 0;
    int          wr_total = 0;
    int          wr_base = 0;
    logic [31:0] exp_rdata = '0;
    logic        exp_err = 1'b0;
    int          exp_lat = 0;
    int          exp_nwr = 0;
    logic [31:0] exp_waddr = '0;
    logic [31:0] exp_wdat = '0;
    logic [31:0] dmem [16];
    logic [31:0] mdl_mem [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Data memory: reads and writes both take effect on the falling edge.
    initial begin
        for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
        dmem[4] = 32'h808182F3;
        forever begin
            @(negedge clk);
            if (mem_MemRW) dmem[mem_addr[5:2]] <= mem_dataW;
            mem_dataR <= dmem[mem_addr[5:2]];
        end
    end

    // Reference: outcome of one request from the width/alignment rules and plain shifts and masks.
    task automatic mdl_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic e,
                          output int lat, output int nwr, output logic [31:0] word);
        int     size;
        int     sh;
        longint mask;
        longint v;
        word = mdl_mem[a[5:2]];
        rd = 32'h0; e = 1'b0; nwr = 0; lat = 0;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (size == 0)               e = 1'b1;
        else if (w && f3[2])         e = 1'b1;
        else if ((a % size) != 0)    e = 1'b1;
        sh = 8 * int'(a % 4);
        mask = (size == 0) ? 64'd0 : ((64'd1 << (8 * size)) - 1);
        if (e) begin
            lat = 1;
        end else if (w) begin
            v = {32'h0, word};
            v = (v & ~(mask << sh)) | ((longint'(wd) & mask) << sh);
            word = v[31:0];
            nwr = 1;
            lat = (size == 4) ? 2 : 3;
        end else begin
            v = (longint'(word) >> sh) & mask;
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
            rd = v[31:0];
            lat = 2;
        end
    endtask

    // Compare process: every falling edge.
    initial begin
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_outputs", {rdata, busy, done, err, mem_addr, mem_dataW, mem_MemRW}, 128'h0);
            end else begin
                chk("mem_addr_aligned", {126'h0, mem_addr[1:0]}, 128'h0);
                if (!busy)
                    chk("idle_quiet", {done, err, mem_MemRW, mem_addr, mem_dataW, rdata}, 128'h0);
                if (mem_MemRW) begin
                    wr_total++;
                    chk("write_allowed", 128'(exp_nwr), 128'd1);
                    chk("write_addr", mem_addr, exp_waddr);
                    chk("write_data", mem_dataW, exp_wdat);
                end
                if (done) begin
                    chk("latency", 128'(cyc - req_cyc), 128'(exp_lat));
                    chk("rdata", rdata, exp_rdata);
                    chk("err", err, exp_err);
                    chk("write_count", 128'(wr_total - wr_base), 128'(exp_nwr));
                    chk("done_outputs", {busy, mem_MemRW, mem_addr, mem_dataW}, {1'b1, 65'h0});
                    chk("done_one_cycle", prev_done, 1'b0);
                end
            end
            prev_done = done;
        end
    end

    task automatic do_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] lit_rd, input logic lit_err,
                         input int lit_lat, input logic [31:0] lit_mem);
        logic [31:0] m_rd, m_word;
        logic        m_err, got;
        int          m_lat, m_nwr;
        mdl_op(w, f3, a, wd, m_rd, m_err, m_lat, m_nwr, m_word);
        chk("model_rdata", m_rd, lit_rd);
        chk("model_err", m_err, lit_err);
        chk("model_lat", 128'(m_lat), 128'(lit_lat));
        @(negedge clk);
        exp_rdata = m_rd; exp_err = m_err; exp_lat = m_lat; exp_nwr = m_nwr;
        exp_waddr = a & 32'hFFFF_FFFC; exp_wdat = m_word;
        wr_base = wr_total; req_cyc = cyc;
        rst = 1'b0; req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
        if (!m_err) mdl_mem[a[5:2]] = m_word;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        req = 1'b0;
        chk("done_seen", got, 1'b1);
        chk("memory_word", dmem[a[5:2]], lit_mem);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mdl_mem[i] = 32'h0;
        mdl_mem[4] = 32'h808182F3;
        #1 rst = 1'b1;
        #1 chk("reset_async", {rdata, busy, done, err, mem_addr, mem_dataW, mem_MemRW}, 128'h0);

        // First request presented together with reset release.
        do_op(0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 0, 2, 32'h808182F3);
        do_op(0, 3'b100, 32'h12, 32'h0,        32'h00000081, 0, 2, 32'h808182F3);
        do_op(0, 3'b001, 32'h12, 32'h0,        32'hFFFF8081, 0, 2, 32'h808182F3);
        do_op(0, 3'b010, 32'h10, 32'h0,        32'h808182F3, 0, 2, 32'h808182F3);
        do_op(1, 3'b000, 32'h11, 32'h000000AB, 32'h0,        0, 3, 32'h8081ABF3);
        do_op(0, 3'b010, 32'h10, 32'h0,        32'h8081ABF3, 0, 2, 32'h8081ABF3);
        do_op(1, 3'b010, 32'h10, 32'h12345678, 32'h0,        0, 2, 32'h12345678);
        do_op(0, 3'b101, 32'h12, 32'h0,        32'h00001234, 0, 2, 32'h12345678);
        do_op(0, 3'b000, 32'h10, 32'h0,        32'h00000078, 0, 2, 32'h12345678);
        do_op(1, 3'b001, 32'h12, 32'h0000CAFE, 32'h0,        0, 3, 32'hCAFE5678);
        do_op(0, 3'b001, 32'h12, 32'h0,        32'hFFFFCAFE, 0, 2, 32'hCAFE5678);
        do_op(0, 3'b001, 32'h11, 32'h0,        32'h0,        1, 1, 32'hCAFE5678);
        do_op(0, 3'b010, 32'h12, 32'h0,        32'h0,        1, 1, 32'hCAFE5678);
        do_op(0, 3'b011, 32'h10, 32'h0,        32'h0,        1, 1, 32'hCAFE5678);
        do_op(1, 3'b100, 32'h10, 32'h000000FF, 32'h0,        1, 1, 32'hCAFE5678);
        do_op(1, 3'b010, 32'h10, 32'h808182F3, 32'h0,        0, 2, 32'h808182F3);

        // SH interrupted by reset after entering WR, before the write negedge.
        @(negedge clk);
        exp_nwr = 0; wr_base = wr_total;
        req = 1'b1; we = 1'b1; funct3 = 3'b001; addr = 32'h10; wdata = 32'h0000BEEF;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1 chk("wr_reached", mem_MemRW, 1'b1);
        rst = 1'b1;
        #1 chk("reset_mid_op", {rdata, busy, done, err, mem_addr, mem_dataW, mem_MemRW}, 128'h0);
        @(negedge clk);
        chk("no_write_on_reset", dmem[4], 32'h808182F3);

        do_op(0, 3'b010, 32'h10, 32'h0,        32'h808182F3, 0, 2, 32'h808182F3);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
